// File: rtl/register_file_dumper.sv
// Walks every register index through the register file's async read port and
// streams each word out over valid/ready. Optional trailer word: DUMP_CHECKSUM_EN.
module register_file_dumper #(
  parameter int NUM_OF_SETS    = 32,
  parameter int DATA_BUS_WIDTH = 32,
  localparam int AW = (NUM_OF_SETS > 1) ? $clog2(NUM_OF_SETS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [AW-1:0]             rf_rd_addr,
  input  logic [DATA_BUS_WIDTH-1:0] rf_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_BUS_WIDTH-1:0] out_data,
  output logic [AW-1:0]             out_addr,
  output logic                      out_last,
  output logic [2:0]                dbg_state
);

  // Output stream: a word transfers on a rising clk edge where out_valid and
  // out_ready are both 1; while out_valid=1 and out_ready=0, out_data, out_addr
  // and out_last stay stable; out_ready is ignored while out_valid=0.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
`ifdef DUMP_CHECKSUM_EN
    CSUM = 3'd4,
`endif
    DONE = 3'd3
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_OF_SETS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_BUS_WIDTH-1:0] csum;
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = READ;
      READ: state_d = SEND;
      SEND: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = READ;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: if (out_valid && out_ready) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        // Capture happens here, so a word reflects the register at this edge.
        READ: begin
          out_data  <= rf_rd_data;
          out_addr  <= idx;
          out_valid <= 1'b1;
          out_last  <= (idx == LAST_IDX) && !CSUM_EN;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum <= csum ^ out_data;
`endif
            if (idx != LAST_IDX) idx <= idx + AW'(1);
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM: begin
          if (!out_valid) begin
            out_data  <= csum;
            out_addr  <= '0;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign rf_rd_addr = (state_q == IDLE) ? '0 : idx;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_register_file_dumper.sv
// Directed bench for register_file_dumper: table of dump scenarios plus
// hand-written reset-abort and checksum sequences.
module tb_register_file_dumper;

  localparam int N  = 32;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int W  = AW + DW + 1;
`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic          busy, done, out_valid, out_last;
  logic [AW-1:0] rf_rd_addr, out_addr;
  logic [DW-1:0] rf_rd_data, out_data;
  logic [2:0]    dbg_state;

  logic [DW-1:0] regs [N];
  assign rf_rd_data = regs[rf_rd_addr];

  always #5 clk = ~clk;

  register_file_dumper #(.NUM_OF_SETS(N), .DATA_BUS_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .dbg_state(dbg_state)
  );

  typedef struct {
    string         name;
    int            stall_at;
    int            stall_len;
    logic [DW-1:0] stall_data;
    int            start_at;
    int            write_at;
    int            write_idx;
    logic [DW-1:0] write_val;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic          done_due;
  int            done_cnt;
  vec_t          vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload_hex11();
    for (int i = 0; i < N; i++) regs[i] = DW'(i * 32'h11);
  endtask

  task automatic push_word(input int addr, input logic [DW-1:0] data, input logic last);
    exp_q.push_back({AW'(addr), data, last});
  endtask

  // Expected stream from the register model, with one pending write applied.
  task automatic push_dump(input int widx, input logic [DW-1:0] wval);
    logic [DW-1:0] x, d;
    x = '0;
    for (int i = 0; i < N; i++) begin
      d = (i == widx) ? wval : regs[i];
      x ^= d;
      push_word(i, d, (CS == 0) && (i == N - 1));
    end
    if (CS == 1) push_word(0, x, 1'b1);
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    @(negedge clk);
    if (done_due) begin
      check("done_after_last", done, 1);
      done_due = 1'b0;
    end
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got addr %0d data 0x%0h, expected no word", out_addr, out_data);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("word_addr%0d", e[W-1 -: AW]), {out_addr, out_data, out_last}, e);
      end
      if (out_last) done_due = 1'b1;
    end
  endtask

  task automatic run_dump(input vec_t v);
    int  cycles, stall_cnt;
    bit  started_mid, wrote, finished;
    cycles = 0; stall_cnt = 0; started_mid = 0; wrote = 0; finished = 0;
    done_cnt = 0; done_due = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    monitor();
    for (int c = 0; c < 600 && !finished; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = 1'b1;
      if (!busy) begin
        finished = 1;
      end else begin
        cycles++;
        if (out_valid && int'(out_addr) == v.stall_at && stall_cnt < v.stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
        end
        if (out_valid && int'(out_addr) == v.start_at && !started_mid) begin
          start = 1'b1;
          started_mid = 1;
        end
        if (out_valid && int'(out_addr) == v.write_at && !wrote) begin
          regs[v.write_idx] = v.write_val;
          wrote = 1;
        end
        monitor();
        if (!out_ready) begin
          check({v.name, "_stall_data"}, out_data, v.stall_data);
          check({v.name, "_stall_addr"}, out_addr, v.stall_at);
        end
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after 600 cycles, expected dump to end", v.name);
    end
    check({v.name, "_done_count"}, done_cnt, 1);
    check({v.name, "_words_left"}, exp_q.size(), 0);
    check({v.name, "_min_cycles"}, cycles >= 2 * (N + CS), 1);
    if (v.stall_len > 0) check({v.name, "_stall_len"}, stall_cnt, v.stall_len);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({v.name, "_idle_after"}, busy, 0);
  endtask

  initial begin
    vec_t plain;
    bit   hit;
    vecs[0] = '{"plain",      -1, 0, 32'h0,  -1, -1, -1, 32'h0};
    vecs[1] = '{"stall7",      7, 5, 32'h77, -1, -1, -1, 32'h0};
    vecs[2] = '{"mid_start",  -1, 0, 32'h0,  10, -1, -1, 32'h0};
    vecs[3] = '{"live_write", -1, 0, 32'h0,  -1,  5, 20, 32'hDEAD};
    plain = vecs[0];

    preload_hex11();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_rf_rd_addr", rf_rd_addr, 0);
    rst = 1'b1;

    for (int t = 0; t < 4; t++) begin
      preload_hex11();
      push_dump(vecs[t].write_idx, vecs[t].write_val);
      run_dump(vecs[t]);
    end

    // Reset while word 15 is on the bus, then a clean restart from address 0.
    preload_hex11();
    push_dump(-1, 32'h0);
    done_due = 1'b0;
    hit = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      monitor();
      if (out_valid && out_addr == AW'(15)) hit = 1;
    end
    check("abort_reached_word15", hit, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rf_rd_addr", rf_rd_addr, 0);
    exp_q.delete();
    done_due = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", done, 0);
    rst = 1'b1;
    push_dump(-1, 32'h0);
    run_dump(plain);

`ifdef DUMP_CHECKSUM_EN
    for (int i = 0; i < N; i++) regs[i] = DW'(i);
    for (int i = 0; i < N; i++) push_word(i, DW'(i), 1'b0);
    push_word(0, 32'h0, 1'b1);
    run_dump(plain);
    regs[1] = 32'hFF;
    for (int i = 0; i < N; i++) push_word(i, regs[i], 1'b0);
    push_word(0, 32'hFE, 1'b1);
    run_dump(plain);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
